score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Game-control and scoring stage directly upstream of the two-digit seven-segment display.
- Runs the round state machine: idle, playing, over.
- Counts hits and misses into a saturating packed-BCD score and counts down the round time in BCD.
- Keeps a session high score and drives the 8-bit packed-BCD value the display multiplexer shows.

Parameters:
- ROUND_SECS, 30, round length in seconds; legal range 1..99, converted to 2-digit BCD at elaboration.
- PENALTY_EN, 1, 1 = a miss decrements the score; 0 = misses are ignored.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tick_1hz  input  1  single-cycle strobe, once per second.
- start  input  1  level from a synchronised, debounced start button.
- hit  input  1  level from the mole-hit detector.
- miss  input  1  level from the miss detector.
- score_bcd  output  8  current score; [7:4] tens, [3:0] ones.
- high_bcd  output  8  session high score, same packing.
- time_bcd  output  8  seconds remaining, same packing.
- disp_bcd  output  8  value for the display: high_bcd in IDLE, score_bcd in PLAYING and OVER.
- state  output  2  00 IDLE, 01 PLAYING, 10 OVER.
- new_high  output  1  high when the last finished round set a new high score.

Behaviour:
- Single clock domain. All registers reset synchronously when rst=1.
- Reset values:
  - state = IDLE
  - score_bcd = 8'h00, high_bcd = 8'h00
  - time_bcd = BCD(ROUND_SECS)
  - new_high = 0
  - edge-detect history registers = 1, so a button held through reset does not fire.
- Edge detection:
  - start, hit and miss are rising-edge detected: ev = in & ~in_q, with in_q registered every cycle.
  - Holding an input high produces exactly one event.
  - Latency: the input is first sampled high at edge n; the resulting register update is visible after edge n+1... more precisely, the event and the register update occur on the same edge n, so the output reads the new value from cycle n+1.
- IDLE:
  - start_ev -> PLAYING; score_bcd <= 00; time_bcd <= BCD(ROUND_SECS); new_high <= 0.
  - hit, miss and tick are ignored.
- PLAYING:
  - hit_ev only: BCD increment. Ones 9 -> 0 with carry into tens; saturates at 99, so 99 stays 99.
  - miss_ev only and PENALTY_EN=1: BCD decrement. Ones 0 -> 9 with borrow from tens; floors at 00.
  - hit_ev and miss_ev in the same cycle: score unchanged when PENALTY_EN=1; counts as a hit when PENALTY_EN=0.
  - tick_1hz: time_bcd BCD decrement.
  - If time_bcd==01 at a tick: time_bcd <= 00 and state <= OVER on that same edge. Score events in that cycle are still applied.
  - start_ev is ignored.
- OVER:
  - Score and time are frozen.
  - Every cycle: if score_bcd > high_bcd (plain unsigned compare, valid for packed BCD), then high_bcd <= score_bcd and new_high <= 1. So high_bcd updates one cycle after OVER is entered.
  - A tie does not set new_high.
  - start_ev -> PLAYING with the same clears as from IDLE. The high-score update completes before any start_ev can be acted on, because OVER lasts at least 1 cycle.
- Output invariant: every output nibble is always in 0..9.
- Undefined state code 11 -> IDLE on the next edge.
- Reset asserted mid-round: all registers take their reset values on the next edge; high_bcd is lost (session only).
- Outputs are registered, except disp_bcd, which is a combinational mux of registered values.

Decomposition:
- Package score_pkg holds:
  - state encodings ST_IDLE, ST_PLAYING, ST_OVER
  - BCD_MAX = 8'h99, BCD_ZERO = 8'h00
  - a function to_bcd2(int) used for ROUND_SECS.
- One sub-module, bcd2_step:
  - combinational, 2-digit packed-BCD +1 / -1 with saturation at 99 / 00
  - instantiated twice: once for the score (up and down) and once for time (down only).

Test Plan:
- Reset with start held high, then release and re-press -> no transition until the re-press. After the press, state=01, score=00, time=BCD(ROUND_SECS)=8'h30.
- In PLAYING, 10 hit rising edges with hit held 5 cycles each -> score goes 01..09 then 8'h10. Each update lands 1 cycle after the rising edge; exactly 10 increments.
- Score 8'h99 plus hit -> stays 99. Score 8'h10 plus miss -> 8'h09. Score 00 plus miss -> 00. hit and miss in the same cycle at 8'h42 -> 8'h42.
- ROUND_SECS=3, 3 ticks -> time 03->02->01->00. State=OVER on the third tick edge. A hit in that same cycle is counted.
- Round ending with score 8'h25 and high 8'h18 -> high=8'h25 and new_high=1, one cycle after OVER. The next round ends at 8'h25 -> high unchanged and new_high=0. disp_bcd shows high in IDLE and score otherwise.
- Reset asserted during PLAYING with score 8'h37 -> next cycle: state=00, score=00, high=00, time=BCD(ROUND_SECS).

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: round state codes,
// packed-BCD limits and the elaboration-time binary-to-BCD helper.
package score_pkg;

    // Round state codes; 2'b11 is never entered on purpose and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAYING = 2'b01,
        ST_OVER    = 2'b10,
        ST_BAD     = 2'b11
    } state_t;

    localparam logic [7:0] BCD_MAX  = 8'h99;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    // Two-digit packed BCD of a small integer. Out-of-range inputs clamp to 0..99.
    function automatic logic [7:0] to_bcd2(input int value);
        int v;
        int t;
        int o;
        v = (value < 0) ? 0 : ((value > 99) ? 99 : value);
        t = v / 10;
        o = v % 10;
        return {4'(t), 4'(o)};
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-control inputs and display-side outputs of the score keeper.
//
// Signal semantics: tick_1hz is a one-cycle strobe and counts on every cycle
// it is high. start, hit and miss are levels; the keeper acts only on the
// cycle where a level is first seen high (rising edge), so holding a level
// produces exactly one event. All outputs are registered except disp_bcd.
interface score_keeper_if;
    logic       tick_1hz;
    logic       start;
    logic       hit;
    logic       miss;
    logic [7:0] score_bcd;
    logic [7:0] high_bcd;
    logic [7:0] time_bcd;
    logic [7:0] disp_bcd;
    logic [1:0] state;
    logic       new_high;

    // Master drives the game inputs and observes the keeper.
    modport master (
        output tick_1hz, start, hit, miss,
        input  score_bcd, high_bcd, time_bcd, disp_bcd, state, new_high
    );

    // Slave is the score keeper itself.
    modport slave (
        input  tick_1hz, start, hit, miss,
        output score_bcd, high_bcd, time_bcd, disp_bcd, state, new_high
    );
endinterface

// File: rtl/bcd2_step.sv
// Combinational 2-digit packed-BCD step: +1 saturating at 99, -1 flooring
// at 00. inc and dec together, or neither, leave the value unchanged.
module bcd2_step
    import score_pkg::*;
(
    input  logic [7:0] val,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = val[7:4];
    assign ones = val[3:0];

    // Ones digit wraps 9->0 / 0->9 with carry / borrow into tens.
    always_comb begin
        result = val;
        if (inc && !dec) begin
            if (val == BCD_MAX) begin
                result = BCD_MAX;
            end else if (ones == 4'd9) begin
                result = {tens + 4'd1, 4'd0};
            end else begin
                result = {tens, ones + 4'd1};
            end
        end else if (dec && !inc) begin
            if (val == BCD_ZERO) begin
                result = BCD_ZERO;
            end else if (ones == 4'd0) begin
                result = {tens - 4'd1, 4'd9};
            end else begin
                result = {tens, ones - 4'd1};
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Round state machine and scoring for the whack-a-mole game: counts hits and
// misses into a saturating BCD score, counts the round time down in BCD,
// keeps the session high score and selects the value for the display.
module score_keeper
    import score_pkg::*;
#(
    parameter int ROUND_SECS = 30,
    parameter bit PENALTY_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave sk
);

    localparam logic [7:0] ROUND_BCD = to_bcd2(ROUND_SECS);

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] high_q, high_d;
    logic [7:0] time_q, time_d;
    logic       new_high_q, new_high_d;

    // Input history; reset to 1 so a level held through reset does not fire.
    logic       start_q, hit_q, miss_q;
    logic       start_ev, hit_ev, miss_ev, miss_pen;

    logic [7:0] score_nxt;
    logic [7:0] time_nxt;

    assign start_ev = sk.start & ~start_q;
    assign hit_ev   = sk.hit   & ~hit_q;
    assign miss_ev  = sk.miss  & ~miss_q;
    assign miss_pen = PENALTY_EN ? miss_ev : 1'b0;

    // Hit and penalised miss together cancel inside the step block.
    bcd2_step u_score_step (
        .val    (score_q),
        .inc    (hit_ev),
        .dec    (miss_pen),
        .result (score_nxt)
    );

    bcd2_step u_time_step (
        .val    (time_q),
        .inc    (1'b0),
        .dec    (1'b1),
        .result (time_nxt)
    );

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            score_q    <= BCD_ZERO;
            high_q     <= BCD_ZERO;
            time_q     <= ROUND_BCD;
            new_high_q <= 1'b0;
            start_q    <= 1'b1;
            hit_q      <= 1'b1;
            miss_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            time_q     <= time_d;
            new_high_q <= new_high_d;
            start_q    <= sk.start;
            hit_q      <= sk.hit;
            miss_q     <= sk.miss;
        end
    end

    // Next-state and datapath updates for each round phase.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        time_d     = time_q;
        new_high_d = new_high_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d    = ST_PLAYING;
                    score_d    = BCD_ZERO;
                    time_d     = ROUND_BCD;
                    new_high_d = 1'b0;
                end
            end
            ST_PLAYING: begin
                score_d = score_nxt;
                if (sk.tick_1hz) begin
                    time_d = time_nxt;
                    // The last second ends the round on the same edge.
                    if (time_q == 8'h01) begin
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                // Packed BCD orders correctly under a plain unsigned compare.
                if (score_q > high_q) begin
                    high_d     = score_q;
                    new_high_d = 1'b1;
                end
                if (start_ev) begin
                    state_d    = ST_PLAYING;
                    score_d    = BCD_ZERO;
                    time_d     = ROUND_BCD;
                    new_high_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sk.score_bcd = score_q;
    assign sk.high_bcd  = high_q;
    assign sk.time_bcd  = time_q;
    assign sk.state     = state_q;
    assign sk.new_high  = new_high_q;
    assign sk.disp_bcd  = (state_q == ST_IDLE) ? high_q : score_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: three instances (30 s with penalty, 3 s with
// penalty, 30 s without penalty), directed table and sequences, then a
// randomized run against an integer-arithmetic reference model.
module tb_score_keeper;

    localparam int W = 35;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] tick_v, start_v, hit_v, miss_v;

    int n_vec;
    int n_err;

    logic [W-1:0] exp_q[$];

    score_keeper_if if_a ();
    score_keeper_if if_b ();
    score_keeper_if if_c ();

    assign if_a.tick_1hz = tick_v[0];
    assign if_a.start    = start_v[0];
    assign if_a.hit      = hit_v[0];
    assign if_a.miss     = miss_v[0];
    assign if_b.tick_1hz = tick_v[1];
    assign if_b.start    = start_v[1];
    assign if_b.hit      = hit_v[1];
    assign if_b.miss     = miss_v[1];
    assign if_c.tick_1hz = tick_v[2];
    assign if_c.start    = start_v[2];
    assign if_c.hit      = hit_v[2];
    assign if_c.miss     = miss_v[2];

    score_keeper #(.ROUND_SECS(30), .PENALTY_EN(1'b1)) dut_a (.clk(clk), .rst(rst_v[0]), .sk(if_a));
    score_keeper #(.ROUND_SECS(3),  .PENALTY_EN(1'b1)) dut_b (.clk(clk), .rst(rst_v[1]), .sk(if_b));
    score_keeper #(.ROUND_SECS(30), .PENALTY_EN(1'b0)) dut_c (.clk(clk), .rst(rst_v[2]), .sk(if_c));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // {state, new_high, score, high, time, disp}
    function automatic logic [W-1:0] snap(input int d);
        case (d)
            0:       return {if_a.state, if_a.new_high, if_a.score_bcd, if_a.high_bcd, if_a.time_bcd, if_a.disp_bcd};
            1:       return {if_b.state, if_b.new_high, if_b.score_bcd, if_b.high_bcd, if_b.time_bcd, if_b.disp_bcd};
            default: return {if_c.state, if_c.new_high, if_c.score_bcd, if_c.high_bcd, if_c.time_bcd, if_c.disp_bcd};
        endcase
    endfunction

    function automatic logic [7:0] g_state(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return {6'b0, s[34:33]};
    endfunction
    function automatic logic [7:0] g_nh(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return {7'b0, s[32]};
    endfunction
    function automatic logic [7:0] g_score(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return s[31:24];
    endfunction
    function automatic logic [7:0] g_high(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return s[23:16];
    endfunction
    function automatic logic [7:0] g_time(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return s[15:8];
    endfunction
    function automatic logic [7:0] g_disp(input int d);
        logic [W-1:0] s;
        s = snap(d);
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        check(name, {27'b0, act}, {27'b0, exp});
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int d);
        rst_v[d] = 1'b1;
        cyc();
        cyc();
        rst_v[d] = 1'b0;
        cyc();
    endtask

    task automatic press_start(input int d);
        start_v[d] = 1'b1;
        cyc();
        start_v[d] = 1'b0;
        cyc();
    endtask

    task automatic hit_once(input int d);
        hit_v[d] = 1'b1;
        cyc();
        hit_v[d] = 1'b0;
        cyc();
    endtask

    task automatic miss_once(input int d);
        miss_v[d] = 1'b1;
        cyc();
        miss_v[d] = 1'b0;
        cyc();
    endtask

    task automatic hits(input int d, input int n);
        for (int i = 0; i < n; i++) hit_once(d);
    endtask

    task automatic tick_once(input int d);
        tick_v[d] = 1'b1;
        cyc();
        tick_v[d] = 1'b0;
    endtask

    // ---------------- reference model (instance A: 30 s, penalty) ----------------
    int m_state, m_score, m_high, m_time, m_nh;
    bit p_start, p_hit, p_miss;

    task automatic model_step(input bit r, input bit ti, input bit st, input bit h, input bit m);
        bit sev, hev, mev;
        if (r) begin
            m_state = 0; m_score = 0; m_high = 0; m_time = 30; m_nh = 0;
            p_start = 1; p_hit = 1; p_miss = 1;
            return;
        end
        sev = st && !p_start;
        hev = h && !p_hit;
        mev = m && !p_miss;
        p_start = st; p_hit = h; p_miss = m;
        if (m_state == 0) begin
            if (sev) begin
                m_state = 1; m_score = 0; m_time = 30; m_nh = 0;
            end
        end else if (m_state == 1) begin
            if (hev && !mev) m_score = (m_score < 99) ? m_score + 1 : 99;
            else if (mev && !hev) m_score = (m_score > 0) ? m_score - 1 : 0;
            if (ti) begin
                if (m_time == 1) begin
                    m_time = 0;
                    m_state = 2;
                end else if (m_time > 0) begin
                    m_time = m_time - 1;
                end
            end
        end else begin
            if (m_score > m_high) begin
                m_high = m_score;
                m_nh = 1;
            end
            if (sev) begin
                m_state = 1; m_score = 0; m_time = 30; m_nh = 0;
            end
        end
    endtask

    function automatic logic [W-1:0] model_snap();
        logic [7:0] dsp;
        dsp = (m_state == 0) ? bcd(m_high) : bcd(m_score);
        return {2'(m_state), 1'(m_nh), bcd(m_score), bcd(m_high), bcd(m_time), dsp};
    endfunction

    // ---------------- table of single-cycle vectors ----------------
    typedef struct {
        logic       h;
        logic       m;
        logic       t;
        logic [7:0] score;
        logic [7:0] tim;
    } vec_t;

    vec_t tbl[13];

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] e;
        bit r, ti, st, h, m;

        n_vec = 0;
        n_err = 0;
        rst_v = 3'b000; tick_v = 3'b000; start_v = 3'b000; hit_v = 3'b000; miss_v = 3'b000;

        // Starting at score 10, time 30, all inputs low on the previous cycle.
        tbl[0]  = '{h: 0, m: 1, t: 0, score: 8'h09, tim: 8'h30};
        tbl[1]  = '{h: 0, m: 0, t: 0, score: 8'h09, tim: 8'h30};
        tbl[2]  = '{h: 0, m: 1, t: 0, score: 8'h08, tim: 8'h30};
        tbl[3]  = '{h: 1, m: 1, t: 1, score: 8'h09, tim: 8'h29};
        tbl[4]  = '{h: 0, m: 0, t: 0, score: 8'h09, tim: 8'h29};
        tbl[5]  = '{h: 1, m: 1, t: 0, score: 8'h09, tim: 8'h29};
        tbl[6]  = '{h: 1, m: 1, t: 1, score: 8'h09, tim: 8'h28};
        tbl[7]  = '{h: 0, m: 0, t: 0, score: 8'h09, tim: 8'h28};
        tbl[8]  = '{h: 0, m: 1, t: 1, score: 8'h08, tim: 8'h27};
        tbl[9]  = '{h: 0, m: 0, t: 0, score: 8'h08, tim: 8'h27};
        tbl[10] = '{h: 1, m: 0, t: 0, score: 8'h09, tim: 8'h27};
        tbl[11] = '{h: 0, m: 0, t: 0, score: 8'h09, tim: 8'h27};
        tbl[12] = '{h: 1, m: 0, t: 0, score: 8'h10, tim: 8'h27};

        // Reset all instances; A has start held through reset.
        start_v[0] = 1'b1;
        rst_v = 3'b111;
        cyc();
        cyc();
        check8("rst_state", g_state(0), 8'h00);
        check8("rst_score", g_score(0), 8'h00);
        check8("rst_high",  g_high(0),  8'h00);
        check8("rst_time",  g_time(0),  8'h30);
        check8("rst_nh",    g_nh(0),    8'h00);
        check8("rst_disp",  g_disp(0),  8'h00);
        check8("rst_time_b", g_time(1), 8'h03);
        rst_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check8("held_start_idle", g_state(0), 8'h00);
        end
        start_v[0] = 1'b0;
        cyc();
        start_v[0] = 1'b1;
        cyc();
        check8("start_state", g_state(0), 8'h01);
        check8("start_score", g_score(0), 8'h00);
        check8("start_time",  g_time(0),  8'h30);
        start_v[0] = 1'b0;
        cyc();

        // Ten hits, each held five cycles: one increment per rising edge.
        for (int k = 1; k <= 10; k++) begin
            hit_v[0] = 1'b1;
            cyc();
            check8("hit_edge", g_score(0), bcd(k));
            for (int j = 0; j < 4; j++) begin
                cyc();
                check8("hit_hold", g_score(0), bcd(k));
            end
            hit_v[0] = 1'b0;
            cyc();
        end

        // Table-driven score/time vectors.
        for (int i = 0; i < 13; i++) begin
            hit_v[0]  = tbl[i].h;
            miss_v[0] = tbl[i].m;
            tick_v[0] = tbl[i].t;
            cyc();
            check8("tbl_score", g_score(0), tbl[i].score);
            check8("tbl_time",  g_time(0),  tbl[i].tim);
        end
        hit_v[0] = 1'b0; miss_v[0] = 1'b0; tick_v[0] = 1'b0;
        cyc();

        // Simultaneous hit and miss at 42 with penalty: unchanged.
        hits(0, 32);
        check8("score_42", g_score(0), 8'h42);
        hit_v[0] = 1'b1; miss_v[0] = 1'b1;
        cyc();
        check8("both_at_42", g_score(0), 8'h42);
        hit_v[0] = 1'b0; miss_v[0] = 1'b0;
        cyc();

        // Saturation at 99.
        hits(0, 57);
        check8("score_99", g_score(0), 8'h99);
        hit_once(0);
        check8("sat_99", g_score(0), 8'h99);
        check8("a_state_playing", g_state(0), 8'h01);

        // Instance C: no penalty, misses ignored, both counts as hit.
        reset_dut(2);
        press_start(2);
        hit_once(2);
        check8("c_hit", g_score(2), 8'h01);
        miss_once(2);
        check8("c_miss_ignored", g_score(2), 8'h01);
        hit_v[2] = 1'b1; miss_v[2] = 1'b1;
        cyc();
        check8("c_both_hit", g_score(2), 8'h02);
        hit_v[2] = 1'b0; miss_v[2] = 1'b0;
        cyc();

        // Instance B: 3-second rounds.
        reset_dut(1);
        press_start(1);
        check8("b_state", g_state(1), 8'h01);
        check8("b_time",  g_time(1),  8'h03);
        miss_once(1);
        check8("b_floor_00", g_score(1), 8'h00);
        hits(1, 17);
        check8("b_score_17", g_score(1), 8'h17);
        tick_once(1);
        check8("b_time_02", g_time(1), 8'h02);
        tick_once(1);
        check8("b_time_01", g_time(1), 8'h01);
        hit_v[1] = 1'b1; tick_v[1] = 1'b1;
        cyc();
        hit_v[1] = 1'b0; tick_v[1] = 1'b0;
        check8("b_end_time",  g_time(1),  8'h00);
        check8("b_end_state", g_state(1), 8'h02);
        check8("b_end_score", g_score(1), 8'h18);
        check8("b_end_high",  g_high(1),  8'h00);
        cyc();
        check8("b_high_18", g_high(1), 8'h18);
        check8("b_nh_r1",   g_nh(1),   8'h01);
        cyc();
        check8("b_frozen_score", g_score(1), 8'h18);
        check8("b_frozen_time",  g_time(1),  8'h00);

        // Round 2 ends at 25 over a high of 18.
        press_start(1);
        check8("b_r2_nh_clr", g_nh(1),   8'h00);
        check8("b_r2_high",   g_high(1), 8'h18);
        check8("b_r2_disp",   g_disp(1), 8'h00);
        hits(1, 25);
        tick_once(1);
        tick_once(1);
        tick_once(1);
        check8("b_r2_over",     g_state(1), 8'h02);
        check8("b_r2_high_old", g_high(1),  8'h18);
        check8("b_r2_nh_old",   g_nh(1),    8'h00);
        cyc();
        check8("b_r2_high_new", g_high(1), 8'h25);
        check8("b_r2_nh",       g_nh(1),   8'h01);
        check8("b_r2_disp_sc",  g_disp(1), 8'h25);

        // Round 3 ties at 25: no new high.
        press_start(1);
        hits(1, 25);
        tick_once(1);
        tick_once(1);
        tick_once(1);
        cyc();
        cyc();
        check8("b_r3_state", g_state(1), 8'h02);
        check8("b_r3_high",  g_high(1),  8'h25);
        check8("b_r3_nh",    g_nh(1),    8'h00);

        // Round 4: reset mid-round at 37 loses everything.
        press_start(1);
        hits(1, 37);
        check8("b_r4_score", g_score(1), 8'h37);
        rst_v[1] = 1'b1;
        cyc();
        rst_v[1] = 1'b0;
        check8("b_mid_rst_state", g_state(1), 8'h00);
        check8("b_mid_rst_score", g_score(1), 8'h00);
        check8("b_mid_rst_high",  g_high(1),  8'h00);
        check8("b_mid_rst_time",  g_time(1),  8'h03);
        check8("b_mid_rst_nh",    g_nh(1),    8'h00);
        check8("b_mid_rst_disp",  g_disp(1),  8'h00);

        // Randomized run on A against the reference model.
        reset_dut(0);
        m_state = 0; m_score = 0; m_high = 0; m_time = 30; m_nh = 0;
        p_start = 0; p_hit = 0; p_miss = 0;
        for (int c = 0; c < 4000; c++) begin
            r  = ($urandom_range(0, 499) == 0);
            ti = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 29) == 0);
            h  = ($urandom_range(0, 1) == 1);
            m  = ($urandom_range(0, 3) == 0);
            rst_v[0] = r; tick_v[0] = ti; start_v[0] = st; hit_v[0] = h; miss_v[0] = m;
            model_step(r, ti, st, h, m);
            exp_q.push_back(model_snap());
            cyc();
            e = exp_q.pop_front();
            check("rand", snap(0), e);
        end
        rst_v = 3'b000; tick_v = 3'b000; start_v = 3'b000; hit_v = 3'b000; miss_v = 3'b000;

        // Final report.
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
